// File: rtl/store_rmw_unit.sv
// Sub-word store engine for a word-wide bus without byte enables.
// Partial stores read the target word, merge the new bytes and write it back.
module store_rmw_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic [5:0]            req_opcode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  done,
  output logic                  err_misaligned,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_waitrequest,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic [DATA_WIDTH-1:0] mem_writedata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam logic [LB-1:0] K_MAX = '1;

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SWR = 6'h2e;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t state, state_d;

  logic [5:0]            op_q;
  logic [LB-1:0]         lane_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [LB-1:0]         req_k;
  logic                  accept;
  logic                  req_store, req_legal, req_full;
  logic                  go_bus, go_direct;

  logic [LB+2:0]         sh_amt;
  logic [DATA_WIDTH-1:0] shifted, byte_mask, merged;
  logic [NB-1:0]         lane_en;

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_k     = req_addr[LB-1:0];

  always_comb begin
    req_store = 1'b0;
    req_legal = 1'b0;
    req_full  = 1'b0;
    case (req_opcode)
      OP_SB:  begin req_store = 1'b1; req_legal = 1'b1; end
      OP_SH:  begin req_store = 1'b1; req_legal = ~req_k[0]; end
      OP_SW:  begin req_store = 1'b1; req_legal = (req_k == '0); req_full = 1'b1; end
      OP_SWL: begin req_store = 1'b1; req_legal = 1'b1; req_full = (req_k == K_MAX); end
      OP_SWR: begin req_store = 1'b1; req_legal = 1'b1; req_full = (req_k == '0); end
      default: ;
    endcase
  end

  assign go_bus    = accept & req_store & req_legal;
  assign go_direct = go_bus & req_full;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (go_bus) state_d = req_full ? S_WRITE : S_READ;
      S_READ:  if (!mem_waitrequest) state_d = S_WRITE;
      S_WRITE: if (!mem_waitrequest) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // SWL aligns rt's top bytes down to lane 0; every other store shifts rt up to lane k.
  always_comb begin
    lane_en   = '0;
    byte_mask = '0;
    sh_amt    = {lane_q, 3'b000};
    if (op_q == OP_SWL) sh_amt = {K_MAX - lane_q, 3'b000};
    shifted = (op_q == OP_SWL) ? (data_q >> sh_amt) : (data_q << sh_amt);
    for (int unsigned j = 0; j < NB; j++) begin
      case (op_q)
        OP_SB:   lane_en[j] = (LB'(j) == lane_q);
        OP_SH:   lane_en[j] = (LB'(j) == lane_q) || (LB'(j) == lane_q + LB'(1));
        OP_SWL:  lane_en[j] = (LB'(j) <= lane_q);
        OP_SWR:  lane_en[j] = (LB'(j) >= lane_q);
        default: lane_en[j] = 1'b1;
      endcase
      byte_mask[8*j +: 8] = {8{lane_en[j]}};
    end
    merged = (shifted & byte_mask) | (mem_readdata & ~byte_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q           <= '0;
      lane_q         <= '0;
      data_q         <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      done           <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      mem_read       <= (state_d == S_READ);
      mem_write      <= (state_d == S_WRITE);
      done           <= (state == S_WRITE) && !mem_waitrequest;
      err_misaligned <= accept & req_store & ~req_legal;
      if (accept) begin
        op_q        <= req_opcode;
        lane_q      <= req_k;
        data_q      <= req_data;
        mem_address <= {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
      end
      if (go_direct)
        mem_writedata <= req_data;
      else if (state == S_READ && !mem_waitrequest)
        mem_writedata <= merged;
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: 32- and 64-bit instances driven by directed and
// random stores, checked cycle by cycle against a byte-level store model.
module tb_store_rmw_unit;

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SWR = 6'h2e;

  logic        clk, reset_n, req_valid, sel64, mem_waitrequest;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [63:0] req_data, mem_readdata;
  logic        v32, v64;

  logic        r32_ready, r32_stall, r32_done, r32_err, r32_read, r32_write;
  logic [31:0] r32_addr, r32_wdata;
  logic        r64_ready, r64_stall, r64_done, r64_err, r64_read, r64_write;
  logic [31:0] r64_addr;
  logic [63:0] r64_wdata;

  int total = 0;
  int passes = 0;
  int fails = 0;

  assign v32 = req_valid & ~sel64;
  assign v64 = req_valid & sel64;

  store_rmw_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .req_valid(v32), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_data(req_data[31:0]), .req_ready(r32_ready),
    .stall(r32_stall), .done(r32_done), .err_misaligned(r32_err),
    .mem_address(r32_addr), .mem_read(r32_read), .mem_write(r32_write),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata[31:0]),
    .mem_writedata(r32_wdata)
  );

  store_rmw_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .req_valid(v64), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_data(req_data), .req_ready(r64_ready),
    .stall(r64_stall), .done(r64_done), .err_misaligned(r64_err),
    .mem_address(r64_addr), .mem_read(r64_read), .mem_write(r64_write),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_writedata(r64_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] status(input bit w);
    if (w) return 64'({r64_ready, r64_stall, r64_read, r64_write, r64_done, r64_err});
    return 64'({r32_ready, r32_stall, r32_read, r32_write, r32_done, r32_err});
  endfunction

  // Byte-level statement of the store rules: which rt byte lands in each lane.
  function automatic logic [63:0] ref_merge(input int nb, input logic [5:0] op, input int k,
                                            input logic [63:0] rt, input logic [63:0] rd);
    logic [63:0] r;
    int src;
    r = rd;
    for (int j = 0; j < nb; j++) begin
      src = -1;
      case (op)
        OP_SB:  if (j == k) src = 0;
        OP_SH:  if (j == k || j == k + 1) src = j - k;
        OP_SW:  src = j;
        OP_SWL: if (j <= k) src = nb - 1 - k + j;
        OP_SWR: if (j >= k) src = j - k;
        default: ;
      endcase
      if (src >= 0) r[8*j +: 8] = rt[8*src +: 8];
    end
    if (nb == 4) r[63:32] = '0;
    return r;
  endfunction

  task automatic run_store(input bit w64, input logic [5:0] op, input logic [31:0] addr,
                           input logic [63:0] rt, input logic [63:0] rd, input int rdw,
                           input int wrw, input bit has_want, input logic [63:0] want);
    int nb, k, rd_end, wr_end, ncyc;
    bit known, legal, full, bus, rmw, e_rd, e_wr, e_done, e_err;
    logic [63:0] exp_wd;
    logic [31:0] exp_addr;
    nb = w64 ? 8 : 4;
    k = int'(addr) & (nb - 1);
    known = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SWL) || (op == OP_SWR);
    legal = !((op == OP_SH && (k % 2) != 0) || (op == OP_SW && k != 0));
    full = (op == OP_SW) || (op == OP_SWL && k == nb - 1) || (op == OP_SWR && k == 0);
    bus = known && legal;
    rmw = bus && !full;
    exp_wd = has_want ? want : ref_merge(nb, op, k, rt, rd);
    exp_addr = addr & ~32'(nb - 1);
    rd_end = rmw ? rdw + 1 : 0;
    wr_end = rd_end + wrw + 1;
    ncyc = bus ? wr_end + 1 : 1;

    @(negedge clk);
    sel64 = w64; req_valid = 1'b1; req_opcode = op; req_addr = addr; req_data = rt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data = {$urandom, $urandom};
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      e_rd = rmw && (c <= rd_end);
      e_wr = bus && (c > rd_end) && (c <= wr_end);
      e_done = bus && (c == wr_end + 1);
      e_err = known && !legal && (c == 1);
      check($sformatf("op%h a%h c%0d status", op, addr, c), status(w64),
            64'({!(e_rd || e_wr), e_rd || e_wr, e_rd, e_wr, e_done, e_err}));
      if (e_rd || e_wr)
        check($sformatf("op%h c%0d address", op, c), w64 ? 64'(r64_addr) : 64'(r32_addr),
              64'(exp_addr));
      if (e_wr)
        check($sformatf("op%h c%0d writedata", op, c), w64 ? r64_wdata : 64'(r32_wdata), exp_wd);
      mem_waitrequest = (e_rd && c < rd_end) || (e_wr && c < wr_end) ||
                        (!(e_rd || e_wr) && ($urandom_range(1) == 1));
      mem_readdata = (e_rd && c == rd_end) ? rd : {$urandom, $urandom};
    end
  endtask

  initial begin
    logic [5:0] ops [5];
    logic [5:0] op;
    ops[0] = OP_SB; ops[1] = OP_SH; ops[2] = OP_SW; ops[3] = OP_SWL; ops[4] = OP_SWR;
    reset_n = 1'b0; req_valid = 1'b0; sel64 = 1'b0; req_opcode = '0; req_addr = '0;
    req_data = '0; mem_waitrequest = 1'b0; mem_readdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset status32", status(1'b0), 64'h20);
    check("reset status64", status(1'b1), 64'h20);
    check("reset addr32", 64'(r32_addr), 64'h0);
    check("reset wdata64", r64_wdata, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_store(1'b0, OP_SB,  32'h1003, 64'h000000AB, 64'h11223344, 0, 0, 1'b1, 64'hAB223344);
    run_store(1'b0, OP_SH,  32'h2002, 64'h0000BEEF, 64'hCAFED00D, 2, 0, 1'b1, 64'hBEEFD00D);
    run_store(1'b0, OP_SW,  32'h3000, 64'hDEADBEEF, 64'h0, 0, 0, 1'b1, 64'hDEADBEEF);
    run_store(1'b0, OP_SW,  32'h3001, 64'hDEADBEEF, 64'h0, 0, 0, 1'b0, 64'h0);
    run_store(1'b0, OP_SWL, 32'h4001, 64'hA1B2C3D4, 64'h55667788, 0, 0, 1'b1, 64'h5566A1B2);
    run_store(1'b0, OP_SWR, 32'h4002, 64'hA1B2C3D4, 64'h55667788, 0, 2, 1'b1, 64'hC3D47788);
    run_store(1'b0, OP_SWL, 32'h4003, 64'hA1B2C3D4, 64'h55667788, 0, 0, 1'b1, 64'hA1B2C3D4);
    run_store(1'b0, OP_SH,  32'h2001, 64'h0000BEEF, 64'h0, 0, 0, 1'b0, 64'h0);
    run_store(1'b0, 6'h2c,  32'h5000, 64'h12345678, 64'h0, 0, 0, 1'b0, 64'h0);
    run_store(1'b1, OP_SB,  32'h8005, 64'hFFFFFFFF0000007E, 64'h0011223344556677, 0, 0, 1'b1,
              64'h00117E3344556677);

    // Reset while a write is stalled by waitrequest.
    @(negedge clk);
    sel64 = 1'b0; req_valid = 1'b1; req_opcode = OP_SW; req_addr = 32'h3000;
    req_data = 64'hDEADBEEF; mem_waitrequest = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst pre status", status(1'b0), 64'h14);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst async status", status(1'b0), 64'h20);
    @(negedge clk);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst after status", status(1'b0), 64'h20);
    end

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(9) == 0) ? 6'h2c : ops[$urandom_range(4)];
      run_store($urandom_range(1) == 1, op, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(2)), int'($urandom_range(2)), 1'b0, 64'h0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
